framebuffer_store: RTL and testbench
====================================

// Module: framebuffer_store
// PURPOSE
//  Double-buffered pixel store sitting between the GPU's framebuffer write port and the video scanout.
//  Accepts single-pixel writes (fb_x, fb_y, fb_color, fb_write) into the back buffer.
//  Serves raster-order pixel reads to the display timing generator from the front buffer.
//  Swaps buffers on request, synchronised to frame start.
// PARAMETERS
//  FB_WIDTH   400  pixels per line
//  FB_HEIGHT  240  lines per frame
//  FB_PIXELS = FB_WIDTH*FB_HEIGHT (localparam). ADDR_W = $clog2(FB_PIXELS) (localparam).
// PORTS
//  clk             in   1                      system clock
//  reset           in   1                      synchronous, active-high reset
//  fb_x            in   $clog2(FB_WIDTH)+1     write x coordinate
//  fb_y            in   $clog2(FB_HEIGHT)+1    write y coordinate
//  fb_color        in   16                     write colour (RGB555 + bit0 opacity, stored verbatim)
//  fb_write        in   1                      write strobe; one pixel per high cycle
//  ctrl_swap       in   1                      rising edge requests a buffer swap
//  swap_pending    out  1                      high from the accepted request until the swap executes
//  back_sel        out  1                      index of the buffer currently being written
//  scan_frame_start in  1                      pulse at start of the visible frame
//  scan_read       in   1                      request next pixel in raster order
//  pixel_data      out  16                     pixel read result
//  pixel_valid     out  1                      high exactly 1 cycle after each accepted scan_read
// BEHAVIOUR
//  Reset: back_sel=1 (front=0), swap_pending=0, pixel_valid=0, pixel_data=0, read pointer=0,
//   write pipeline flushed (no write issued in the cycle after reset). RAM contents not cleared.
//  Write path, 2-stage: cycle 0 samples fb_*; drops the write if fb_x>=FB_WIDTH or fb_y>=FB_HEIGHT
//   (unsigned compare); registers addr=fb_y*FB_WIDTH+fb_x (ADDR_W bits), colour, back_sel.
//   Cycle 1 commits to RAM. Buffer target is latched in cycle 0: a swap in cycle 1 does not redirect it.
//   Back-to-back writes every cycle sustained; no backpressure; same address twice -> last wins.
//  Swap FSM: IDLE -> PENDING on ctrl_swap rising edge (edge detect via registered old_ctrl_swap,
//   cleared on reset). PENDING -> IDLE on scan_frame_start: back_sel toggles in that cycle.
//   Edge while PENDING is ignored (no queueing). Edge and scan_frame_start in same cycle from IDLE:
//   request is taken, swap waits for the NEXT frame start. swap_pending = (state==PENDING).
//  Read path: pointer counts 0..FB_PIXELS. scan_read: RAM read of front buffer at pointer,
//   pointer+1 (saturates at FB_PIXELS); data on pixel_data with pixel_valid the next cycle.
//   Reads at pointer==FB_PIXELS return 16'h0000 with pixel_valid=1.
//   scan_frame_start: pointer <= 0; if also scan_read the same cycle, pixel 0 is read and pointer <= 1.
//   When scan_frame_start performs a swap, that cycle's read already uses the NEW front buffer.
//  pixel_data holds its last value when pixel_valid=0.
//  Read/write same physical address same cycle: only possible after a swap retargets a pending
//   write; read returns the old RAM contents (read-first).
//  Reset mid-operation: in-flight write discarded, pending swap cancelled, pointer to 0.
// STRUCTURE
//  Shared header gpu_defs.vh: FB_WIDTH/FB_HEIGHT defaults, pixel width 16, opacity bit index 0,
//   so the GPU and this block agree on geometry.
//  Sub-module fb_ram: simple dual-port RAM, 2*FB_PIXELS x 16, one write port, one registered read
//   port, address = {buffer_bit, ADDR_W-bit index}; must infer block RAM.
//  Top holds write pipeline, swap FSM, read pointer.
// TESTING
//  Reset, write (3,2)=16'hABCD, swap + frame_start, read 2*400+4 pixels -> pixel 803 = ABCD, rest as preloaded.
//  Writes at x=400 or y=240 or x=1023 -> no RAM change (back buffer checksum unchanged).
//  ctrl_swap rising edge, 2 more edges, then frame_start -> exactly one toggle, swap_pending 1->0 that cycle.
//  fb_write at (0,0) in the cycle before the swap's frame_start -> pixel lands in the old back buffer, now front.
//  96000+2 scan_reads after frame_start -> last valid pixel (399,239), then 2 reads of 16'h0000; frame_start+read -> pixel 0.
//  Reset asserted one cycle after fb_write and during PENDING -> write lost, swap_pending=0, back_sel=1.

Source files
------------

// File: rtl/framebuffer_store_pkg.sv
// Shared framebuffer geometry and swap FSM encoding for the GPU and scanout.
package framebuffer_store_pkg;

  localparam int unsigned FB_WIDTH_DEF  = 400;
  localparam int unsigned FB_HEIGHT_DEF = 240;
  localparam int unsigned PIX_W         = 16;

  // IDLE=0 / PENDING=1 so the state bit doubles as the swap_pending flag.
  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/framebuffer_store_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port, read-first.
module framebuffer_store_ram #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Address is {buffer_bit, pixel_index}, so depth covers the full concatenated space.
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write and read share one clocked block; non-blocking read returns pre-write data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/framebuffer_store.sv
// Double-buffered pixel store: GPU writes the back buffer, scanout reads the front buffer.
module framebuffer_store
  import framebuffer_store_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
  parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(FB_WIDTH):0]    fb_x,
  input  logic [$clog2(FB_HEIGHT):0]   fb_y,
  input  logic [PIX_W-1:0]             fb_color,
  input  logic                         fb_write,
  input  logic                         ctrl_swap,
  output logic                         swap_pending,
  output logic                         back_sel,
  input  logic                         scan_frame_start,
  input  logic                         scan_read,
  output logic [PIX_W-1:0]             pixel_data,
  output logic                         pixel_valid
);

  localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned ADDR_W    = $clog2(FB_PIXELS);
  localparam int unsigned PTR_W     = $clog2(FB_PIXELS + 1);
  localparam int unsigned X_W       = $clog2(FB_WIDTH) + 1;
  localparam int unsigned Y_W       = $clog2(FB_HEIGHT) + 1;

  swap_state_e        state_q, state_d;
  logic               old_ctrl_swap_q, old_ctrl_swap_d;
  logic               back_sel_q, back_sel_d;
  logic               wr_valid_q, wr_valid_d;
  logic               wr_buf_q, wr_buf_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]   wr_color_q, wr_color_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               pixel_valid_q, pixel_valid_d;
  logic               rd_blank_q, rd_blank_d;

  logic               swap_edge_c;
  logic               in_range_c;
  logic [PTR_W-1:0]   rd_ptr_eff_c;
  logic               rd_at_end_c;
  logic               rd_en_c;
  logic               ram_we_c;
  logic [ADDR_W:0]    ram_wr_addr_c;
  logic [ADDR_W:0]    ram_rd_addr_c;
  logic [PIX_W-1:0]   ram_rd_data;

  // Write stage 0: bounds check, linear address and buffer target captured here.
  always_comb begin
    in_range_c = (fb_x < X_W'(FB_WIDTH)) && (fb_y < Y_W'(FB_HEIGHT));
    wr_valid_d = fb_write && in_range_c;
    wr_addr_d  = ADDR_W'(fb_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(fb_x);
    wr_color_d = fb_color;
    wr_buf_d   = back_sel_q;
  end

  // Swap FSM: rising edge of ctrl_swap arms, next frame start toggles back_sel.
  always_comb begin
    state_d         = state_q;
    back_sel_d      = back_sel_q;
    old_ctrl_swap_d = ctrl_swap;
    swap_edge_c     = ctrl_swap && !old_ctrl_swap_q;
    case (state_q)
      SWAP_IDLE: begin
        if (swap_edge_c) begin
          state_d = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        if (scan_frame_start) begin
          state_d    = SWAP_IDLE;
          back_sel_d = !back_sel_q;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  // Read path: frame start rewinds the pointer; reads past the last pixel return zero.
  always_comb begin
    rd_ptr_eff_c  = scan_frame_start ? '0 : rd_ptr_q;
    rd_at_end_c   = (rd_ptr_eff_c == PTR_W'(FB_PIXELS));
    rd_en_c       = scan_read && !rd_at_end_c;
    rd_ptr_d      = rd_ptr_eff_c;
    if (rd_en_c) begin
      rd_ptr_d = rd_ptr_eff_c + PTR_W'(1);
    end
    pixel_valid_d = scan_read;
    rd_blank_d    = scan_read ? rd_at_end_c : rd_blank_q;
  end

  // RAM port mapping; a swap this cycle already redirects the read to the new front.
  always_comb begin
    ram_we_c      = wr_valid_q && !reset;
    ram_wr_addr_c = {wr_buf_q, wr_addr_q};
    ram_rd_addr_c = {!back_sel_d, ADDR_W'(rd_ptr_eff_c)};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= SWAP_IDLE;
      old_ctrl_swap_q <= 1'b0;
      back_sel_q      <= 1'b1;
      wr_valid_q      <= 1'b0;
      wr_buf_q        <= 1'b0;
      wr_addr_q       <= '0;
      wr_color_q      <= '0;
      rd_ptr_q        <= '0;
      pixel_valid_q   <= 1'b0;
      rd_blank_q      <= 1'b1;
    end else begin
      state_q         <= state_d;
      old_ctrl_swap_q <= old_ctrl_swap_d;
      back_sel_q      <= back_sel_d;
      wr_valid_q      <= wr_valid_d;
      wr_buf_q        <= wr_buf_d;
      wr_addr_q       <= wr_addr_d;
      wr_color_q      <= wr_color_d;
      rd_ptr_q        <= rd_ptr_d;
      pixel_valid_q   <= pixel_valid_d;
      rd_blank_q      <= rd_blank_d;
    end
  end

  framebuffer_store_ram #(
    .ADDR_W (ADDR_W + 1),
    .DATA_W (PIX_W)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we_c),
    .wr_addr (ram_wr_addr_c),
    .wr_data (wr_color_q),
    .rd_en   (rd_en_c),
    .rd_addr (ram_rd_addr_c),
    .rd_data (ram_rd_data)
  );

  // Blank flag (set at reset and on end-of-frame reads) forces zero without resetting RAM.
  assign pixel_data   = rd_blank_q ? '0 : ram_rd_data;
  assign pixel_valid  = pixel_valid_q;
  assign back_sel     = back_sel_q;
  assign swap_pending = (state_q == SWAP_PENDING);

endmodule

// File: tb/tb_framebuffer_store.sv
// Directed bench for framebuffer_store: write table, swap sequencing, full-frame scan, reset.
module tb_framebuffer_store;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  fb_x;
  logic [8:0]  fb_y;
  logic [15:0] fb_color;
  logic        fb_write;
  logic        ctrl_swap;
  logic        swap_pending;
  logic        back_sel;
  logic        scan_frame_start;
  logic        scan_read;
  logic [15:0] pixel_data;
  logic        pixel_valid;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [15:0] color;
    bit          hit;
    int          addr;
  } wr_vec_t;

  wr_vec_t     tbl[14];
  logic [15:0] img[int];
  logic [15:0] rd_q[$];
  int          valid_cnt;

  always #5 clk = ~clk;

  framebuffer_store dut (
    .clk              (clk),
    .reset            (reset),
    .fb_x             (fb_x),
    .fb_y             (fb_y),
    .fb_color         (fb_color),
    .fb_write         (fb_write),
    .ctrl_swap        (ctrl_swap),
    .swap_pending     (swap_pending),
    .back_sel         (back_sel),
    .scan_frame_start (scan_frame_start),
    .scan_read        (scan_read),
    .pixel_data       (pixel_data),
    .pixel_valid      (pixel_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream n back-to-back reads; result of read i is visible right after edge i.
  task automatic scan(input int n, input bit fs);
    rd_q.delete();
    valid_cnt        = 0;
    scan_frame_start = fs;
    scan_read        = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      scan_frame_start = 1'b0;
      if (pixel_valid) valid_cnt++;
      rd_q.push_back(pixel_data);
    end
    scan_read = 1'b0;
  endtask

  task automatic write_px(input logic [9:0] x, input logic [8:0] y, input logic [15:0] c);
    fb_x     = x;
    fb_y     = y;
    fb_color = c;
    fb_write = 1'b1;
    step();
    fb_write = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{10'd3,    9'd2,   16'hABCD, 1'b1, 803};
    tbl[1]  = '{10'd0,    9'd1,   16'h1111, 1'b1, 400};
    tbl[2]  = '{10'd223,  9'd2,   16'h2222, 1'b1, 1023};
    tbl[3]  = '{10'd0,    9'd0,   16'h3333, 1'b1, 0};
    tbl[4]  = '{10'd399,  9'd0,   16'h4444, 1'b1, 399};
    tbl[5]  = '{10'd5,    9'd0,   16'h5555, 1'b1, 5};
    tbl[6]  = '{10'd5,    9'd0,   16'h6666, 1'b1, 5};
    tbl[7]  = '{10'd399,  9'd1,   16'h7777, 1'b1, 799};
    tbl[8]  = '{10'd0,    9'd2,   16'h8888, 1'b1, 800};
    tbl[9]  = '{10'd400,  9'd0,   16'hDEAD, 1'b0, 400};
    tbl[10] = '{10'd1023, 9'd0,   16'hBEEF, 1'b0, 1023};
    tbl[11] = '{10'd400,  9'd1,   16'hF00D, 1'b0, 800};
    tbl[12] = '{10'd0,    9'd240, 16'hBAD0, 1'b0, 0};
    tbl[13] = '{10'd1023, 9'd511, 16'h0BAD, 1'b0, 0};

    reset = 1'b1; fb_x = '0; fb_y = '0; fb_color = '0; fb_write = 1'b0;
    ctrl_swap = 1'b0; scan_frame_start = 1'b0; scan_read = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_back_sel",     32'(back_sel),     32'd1);
    check("rst_swap_pending", 32'(swap_pending), 32'd0);
    check("rst_pixel_valid",  32'(pixel_valid),  32'd0);
    check("rst_pixel_data",   32'(pixel_data),   32'd0);

    // Back-to-back table writes into back buffer 1, including out-of-range aliases.
    for (int i = 0; i < 14; i++) begin
      fb_x = tbl[i].x; fb_y = tbl[i].y; fb_color = tbl[i].color; fb_write = 1'b1;
      step();
      if (tbl[i].hit) img[tbl[i].addr] = tbl[i].color;
    end
    fb_write = 1'b0;
    step(); step();

    // One accepted edge, two ignored edges, then the frame start executes the swap.
    ctrl_swap = 1'b1; step();
    check("swap_req_pending", 32'(swap_pending), 32'd1);
    ctrl_swap = 1'b0; step();
    ctrl_swap = 1'b1; step();
    ctrl_swap = 1'b0; step();
    ctrl_swap = 1'b1; step();
    ctrl_swap = 1'b0;
    check("no_toggle_before_fs", 32'(back_sel),     32'd1);
    check("still_pending",       32'(swap_pending), 32'd1);
    scan_frame_start = 1'b1; step(); scan_frame_start = 1'b0;
    check("fs_toggle",        32'(back_sel),     32'd0);
    check("fs_clears_pending", 32'(swap_pending), 32'd0);
    scan_frame_start = 1'b1; step(); scan_frame_start = 1'b0;
    check("single_toggle",    32'(back_sel),     32'd0);

    scan(1024, 1'b1);
    check("scan1k_valid", 32'(valid_cnt), 32'd1024);
    check("pix_803", 32'(rd_q[803]), 32'hABCD);
    foreach (img[a]) check($sformatf("pix_%0d", a), 32'(rd_q[a]), 32'(img[a]));

    // Swap request coincident with frame start waits for the next frame start.
    write_px(10'd0, 9'd0, 16'h0BAD);
    step();
    ctrl_swap = 1'b1; scan_frame_start = 1'b1; step();
    ctrl_swap = 1'b0; scan_frame_start = 1'b0;
    check("edge_fs_pending", 32'(swap_pending), 32'd1);
    check("edge_fs_no_swap", 32'(back_sel),     32'd0);

    // Write just before the swap's frame start stays in the old back buffer; read is read-first.
    fb_x = '0; fb_y = '0; fb_color = 16'hCAFE; fb_write = 1'b1; step();
    fb_write = 1'b0; scan_frame_start = 1'b1; scan_read = 1'b1; step();
    scan_frame_start = 1'b0; scan_read = 1'b0;
    check("late_swap_back_sel", 32'(back_sel),     32'd1);
    check("late_swap_pending",  32'(swap_pending), 32'd0);
    check("read_first_valid",   32'(pixel_valid),  32'd1);
    check("read_first_data",    32'(pixel_data),   32'h0BAD);
    step();
    check("hold_valid", 32'(pixel_valid), 32'd0);
    check("hold_data",  32'(pixel_data),  32'h0BAD);
    scan(1, 1'b1);
    check("late_write_landed", 32'(rd_q[0]), 32'hCAFE);

    // Full frame plus two overrun reads; swap executes on the scan's own frame start.
    write_px(10'd399, 9'd239, 16'h7E57);
    step();
    ctrl_swap = 1'b1; step(); ctrl_swap = 1'b0;
    scan(96002, 1'b1);
    check("full_back_sel",  32'(back_sel),     32'd0);
    check("full_valid_cnt", 32'(valid_cnt),    32'd96002);
    check("full_pix0",      32'(rd_q[0]),      32'h3333);
    check("full_pix803",    32'(rd_q[803]),    32'hABCD);
    check("last_pixel",     32'(rd_q[95999]),  32'h7E57);
    check("overrun_0",      32'(rd_q[96000]),  32'h0000);
    check("overrun_1",      32'(rd_q[96001]),  32'h0000);
    scan(1, 1'b1);
    check("fs_rewind_pix0", 32'(rd_q[0]),      32'h3333);

    // Reset one cycle after a write and while a swap is pending.
    fb_x = '0; fb_y = '0; fb_color = 16'h9999; fb_write = 1'b1; ctrl_swap = 1'b1;
    step();
    fb_write = 1'b0; ctrl_swap = 1'b0;
    check("pre_rst_pending", 32'(swap_pending), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check("mid_rst_pending",  32'(swap_pending), 32'd0);
    check("mid_rst_back_sel", 32'(back_sel),     32'd1);
    check("mid_rst_valid",    32'(pixel_valid),  32'd0);
    check("mid_rst_data",     32'(pixel_data),   32'd0);
    scan(1, 1'b0);
    check("rst_ptr_valid",    32'(valid_cnt),    32'd1);
    check("rst_write_lost",   32'(rd_q[0]),      32'hCAFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
